// File: rtl/mxint_block_stim_gen.sv
// MXINT block stimulus sequencer: walks 13 corner-case classes, emitting one
// shared-scale block of signed elements per valid/ready handshake.
module mxint_block_stim_gen #(
  parameter int          ELEM_WIDTH  = 8,
  parameter int          SCALE_WIDTH = 8,
  parameter int          BLOCK_SIZE  = 32,
  parameter int          REPEAT      = 5,
  parameter logic [31:0] LFSR_SEED   = 32'h1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [12:0]                      case_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SCALE_WIDTH-1:0]           scale,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements,
  output logic [3:0]                       case_id,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      vec_cnt
);

  localparam int W  = ELEM_WIDTH;
  localparam int EW = BLOCK_SIZE * ELEM_WIDTH;

  localparam logic [31:0]  SEED      = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [15:0]  LAST_REP0 = 16'(5 * REPEAT - 1);
  localparam logic [15:0]  LAST_REPN = 16'(REPEAT - 1);
  localparam logic [4:0]   NO_CASE   = 5'd13;

  localparam logic [W-1:0] E_ZERO  = {W{1'b0}};
  localparam logic [W-1:0] E_ONES  = {W{1'b1}};
  localparam logic [W-1:0] E_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] E_UNUSE = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] E_MAXP  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] E_NMAXP = {1'b1, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Lowest enabled case index >= from, or NO_CASE when none remain.
  function automatic logic [4:0] find_case(input logic [12:0] en, input logic [4:0] from);
    logic [4:0] r;
    r = NO_CASE;
    for (int k = 12; k >= 0; k--) begin
      if (en[k] && (5'(k) >= from)) r = 5'(k);
    end
    return r;
  endfunction

  function automatic logic [SCALE_WIDTH-1:0] gen_scale(input logic [31:0] s, input logic [3:0] cid);
    logic [SCALE_WIDTH-1:0] rs;
    rs = s[31 -: SCALE_WIDTH];
    if (&rs) rs[0] = 1'b0;
    if ((cid == 4'd11) || (cid == 4'd12)) rs = {SCALE_WIDTH{1'b1}};
    return rs;
  endfunction

  function automatic logic [EW-1:0] gen_elems(input logic [31:0] s, input logic [3:0] cid);
    logic [EW-1:0] e;
    logic [W-1:0]  raw;
    logic [W-1:0]  nrm;
    logic [W-1:0]  v;
    logic [31:0]   idx;
    idx = (s >> 8) & 32'(BLOCK_SIZE - 1);
    e   = {EW{1'b0}};
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      raw = W'(s ^ (32'(i) * 32'h9E3779B9));
      nrm = (raw == E_UNUSE) ? E_ZERO : raw;
      case (cid)
        4'd0, 4'd11: v = nrm;
        4'd1: begin
          v = {1'b0, raw[W-2:0]};
          if (v == E_ZERO) v = E_ONE;
        end
        4'd2: begin
          v = {1'b1, raw[W-2:0]};
          if (v == E_UNUSE) v = E_ONES;
        end
        4'd3: v = W'($signed(raw[3:0]));
        4'd4: begin
          // Magnitude forced into the top binade so every element is "big".
          v = {2'b01, raw[W-3:0]};
          if (raw[W-1]) v = -v;
        end
        4'd5:        v = E_ZERO;
        4'd6:        v = (32'(i) == idx) ? E_ZERO : nrm;
        4'd7:        v = E_UNUSE;
        4'd8, 4'd12: v = (32'(i) == idx) ? E_UNUSE : nrm;
        4'd9:        v = E_MAXP;
        4'd10:       v = E_NMAXP;
        default:     v = E_ZERO;
      endcase
      e[i*W +: W] = v;
    end
    return e;
  endfunction

  state_t                 state_q, state_d;
  logic [12:0]            en_q, en_d;
  logic [3:0]             case_q, case_d;
  logic [15:0]            rep_q, rep_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [15:0]            vec_q, vec_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [EW-1:0]          elem_q, elem_d;

  logic                   hs_s;
  logic [4:0]             first_case_s;
  logic [4:0]             next_case_s;
  logic [15:0]            rep_last_s;

  // Sequencer next state, handshake bookkeeping and next block contents.
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    case_d       = case_q;
    rep_d        = rep_q;
    lfsr_d       = lfsr_q;
    vec_d        = vec_q;
    hs_s         = valid_q & out_ready;
    first_case_s = find_case(case_en, 5'd0);
    next_case_s  = find_case(en_q, {1'b0, case_q} + 5'd1);
    rep_last_s   = (case_q == 4'd0) ? LAST_REP0 : LAST_REPN;

    case (state_q)
      IDLE: begin
        if (start) begin
          en_d  = case_en;
          vec_d = 16'd0;
          rep_d = 16'd0;
          if (case_en == 13'd0) begin
            state_d = FIN;
          end else begin
            state_d = LOAD;
            case_d  = first_case_s[3:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (hs_s) begin
          lfsr_d = lfsr_next(lfsr_q);
          vec_d  = (vec_q == 16'hFFFF) ? vec_q : vec_q + 16'd1;
          if (rep_q == rep_last_s) begin
            rep_d = 16'd0;
            if (next_case_s != NO_CASE) begin
              case_d = next_case_s[3:0];
            end else begin
              state_d = FIN;
            end
          end else begin
            rep_d = rep_q + 16'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == FIN);

    // Data is only recomputed for a presented block, so stalls hold it.
    if (state_d == RUN) begin
      scale_d = gen_scale(lfsr_d, case_d);
      elem_d  = gen_elems(lfsr_d, case_d);
    end else begin
      scale_d = scale_q;
      elem_d  = elem_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 13'd0;
      case_q  <= 4'd0;
      rep_q   <= 16'd0;
      lfsr_q  <= SEED;
      vec_q   <= 16'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scale_q <= {SCALE_WIDTH{1'b0}};
      elem_q  <= {EW{1'b0}};
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      case_q  <= case_d;
      rep_q   <= rep_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scale_q <= scale_d;
      elem_q  <= elem_d;
    end
  end

  assign out_valid = valid_q;
  assign scale     = scale_q;
  assign elements  = elem_q;
  assign case_id   = case_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_cnt   = vec_q;

endmodule
